// File: rtl/lx32_debug_console.sv
// lx32_debug_console
//   Memory-mapped debug console on the lx32 data bus. Core stores to the
//   per-channel DATA registers are buffered in small FIFOs. A round-robin
//   arbiter drains them through one registered valid/ready stream. An EXIT
//   register captures a sticky simulation exit code.
//
// Ports
//   clk, rst_n               system clock, async active-low reset
//   mem_addr/wdata/we        core store interface
//   mem_rdata, sel           combinational read data and block-hit flag
//   drain_valid/data/ch      registered output stream
//   drain_ready              consumer accept
//   done, exit_code          sticky exit flag and first exit value
//
// Register map (byte offsets from BASE_ADDR)
//   0x0          STATUS  empty[ch] | full[ch]<<8 | ovf[ch]<<16 | done<<31
//   0x4          CTRL    write 1s to clear overflow bits
//   0x8          EXIT    first write sets done and exit_code
//   0xC + 4*ch   DATA ch push into FIFO ch
module lx32_debug_console #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_07F0,
    parameter int          NUM_CH     = 2,
    parameter int          FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_we,
    output logic [31:0] mem_rdata,
    output logic        sel,
    output logic        drain_valid,
    output logic [31:0] drain_data,
    output logic [2:0]  drain_ch,
    input  logic        drain_ready,
    output logic        done,
    output logic [31:0] exit_code
);

    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [31:0] END_OFF = 32'(12 + 4 * NUM_CH);

    logic [31:0]       fifo_mem_q [NUM_CH][FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q   [NUM_CH];
    logic [PW-1:0]     wr_ptr_d   [NUM_CH];
    logic [PW-1:0]     rd_ptr_q   [NUM_CH];
    logic [PW-1:0]     rd_ptr_d   [NUM_CH];
    logic [CW-1:0]     cnt_q      [NUM_CH];
    logic [CW-1:0]     cnt_d      [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic              done_q, done_d;
    logic [31:0]       exit_code_q, exit_code_d;
    logic              drain_valid_q, drain_valid_d;
    logic [31:0]       drain_data_q, drain_data_d;
    logic [2:0]        drain_ch_q, drain_ch_d;
    logic [2:0]        rr_ptr_q, rr_ptr_d;

    logic [31:0]       off;
    logic              hit;
    logic              wr_ctrl, wr_exit;
    logic [NUM_CH-1:0] empty, full, push, pop, accept;
    logic [31:0]       status;
    logic              load;
    logic              grant_found;
    logic [2:0]        grant;
    logic [31:0]       head_data;

    // Subtracting first keeps the compare exact over all 32 bits, so no
    // high-address aliases of the block decode as hits.
    assign off     = mem_addr - BASE_ADDR;
    assign hit     = (mem_addr >= BASE_ADDR) && (off < END_OFF) && (off[1:0] == 2'b00);
    assign wr_ctrl = mem_we && hit && (off == 32'h4);
    assign wr_exit = mem_we && hit && (off == 32'h8);

    always_comb begin
        status = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            empty[c]       = (cnt_q[c] == '0);
            full[c]        = (cnt_q[c] == CW'(FIFO_DEPTH));
            push[c]        = mem_we && hit && (off == 32'(12 + 4 * c));
            status[c]      = empty[c];
            status[8 + c]  = full[c];
            status[16 + c] = ovf_q[c];
        end
        status[31] = done_q;
    end

    assign sel       = hit;
    assign mem_rdata = (hit && (off == 32'h0)) ? status : 32'h0;

    // Round-robin search starting at rr_ptr; rr_ptr is always < NUM_CH, so
    // a single subtraction is enough to wrap.
    always_comb begin : arb_comb
        int idx;
        idx         = 0;
        grant       = '0;
        grant_found = 1'b0;
        head_data   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (!grant_found && !empty[idx]) begin
                grant_found = 1'b1;
                grant       = 3'(idx);
                head_data   = fifo_mem_q[idx][rd_ptr_q[idx]];
            end
        end
    end

    assign load = (!drain_valid_q || drain_ready) && grant_found;

    always_comb begin
        ovf_d = ovf_q;
        if (wr_ctrl) ovf_d = ovf_q & ~mem_wdata[NUM_CH-1:0];
        for (int c = 0; c < NUM_CH; c++) begin
            pop[c] = load && (grant == 3'(c));
            // A full FIFO still takes the store when its head leaves on this edge.
            accept[c]   = push[c] && (!full[c] || pop[c]);
            wr_ptr_d[c] = wr_ptr_q[c] + PW'(accept[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + PW'(pop[c]);
            cnt_d[c]    = cnt_q[c] + CW'(accept[c]) - CW'(pop[c]);
            // Applied after the CTRL clear so a same-edge overflow wins.
            if (push[c] && full[c] && !pop[c]) ovf_d[c] = 1'b1;
        end

        done_d      = done_q;
        exit_code_d = exit_code_q;
        if (wr_exit && !done_q) begin
            done_d      = 1'b1;
            exit_code_d = mem_wdata;
        end

        drain_valid_d = drain_valid_q;
        drain_data_d  = drain_data_q;
        drain_ch_d    = drain_ch_q;
        rr_ptr_d      = rr_ptr_q;
        if (load) begin
            drain_valid_d = 1'b1;
            drain_data_d  = head_data;
            drain_ch_d    = grant;
            rr_ptr_d      = (grant == 3'(NUM_CH - 1)) ? 3'd0 : grant + 3'd1;
        end else if (drain_valid_q && drain_ready) begin
            drain_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                cnt_q[c]    <= '0;
            end
            ovf_q         <= '0;
            done_q        <= 1'b0;
            exit_code_q   <= '0;
            drain_valid_q <= 1'b0;
            drain_data_q  <= '0;
            drain_ch_q    <= '0;
            rr_ptr_q      <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr_q[c] <= wr_ptr_d[c];
                rd_ptr_q[c] <= rd_ptr_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
            ovf_q         <= ovf_d;
            done_q        <= done_d;
            exit_code_q   <= exit_code_d;
            drain_valid_q <= drain_valid_d;
            drain_data_q  <= drain_data_d;
            drain_ch_q    <= drain_ch_d;
            rr_ptr_q      <= rr_ptr_d;
        end
    end

    // Storage needs no reset: occupancy counters define what is valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (accept[c]) fifo_mem_q[c][wr_ptr_q[c]] <= mem_wdata;
        end
    end

    assign drain_valid = drain_valid_q;
    assign drain_data  = drain_data_q;
    assign drain_ch    = drain_ch_q;
    assign done        = done_q;
    assign exit_code   = exit_code_q;

endmodule

// File: doc/lx32_debug_console.md
Name: lx32_debug_console

Overview:
Memory-mapped debug console peripheral on the lx32 data bus. It replaces the single fixed-address write monitor with NUM_CH buffered character/word channels, a status register, and a simulation-exit register. Core stores are captured into per-channel FIFOs. A round-robin arbiter drains the FIFOs through one registered valid/ready stream toward a host, bench or UART.

Parameters:
BASE_ADDR, 32'h0000_07F0, byte address of register block (16-byte aligned)
NUM_CH, 2, number of console channels (1..8)
FIFO_DEPTH, 8, entries per channel FIFO (power of 2, >=2)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
mem_addr  in  32  core data address
mem_wdata  in  32  core store data
mem_we  in  1  core store strobe
mem_rdata  out  32  read data, combinational, valid when sel=1
sel  out  1  mem_addr hits register block (combinational)
drain_valid  out  1  drain stream word available (registered)
drain_data  out  32  drain word (registered)
drain_ch  out  3  source channel of drain word (registered)
drain_ready  in  1  consumer accepts word
done  out  1  exit register written (sticky)
exit_code  out  32  value of first exit write

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low; assertion takes effect immediately, deassertion is synchronous to clk.
- Register map, byte offsets from BASE_ADDR, full 32-bit compare, no partial-address aliasing:
  - 0x0 STATUS, read-only:
    - bit ch = FIFO ch empty
    - bit 8+ch = FIFO ch full
    - bit 16+ch = overflow sticky for ch
    - bit 31 = done
    - unused bits read 0
  - 0x4 CTRL, write: bits[NUM_CH-1:0] set to 1 clear the matching overflow bits. Reads 0.
  - 0x8 EXIT, write: if done=0, set done=1 and exit_code=wdata. Later writes are ignored.
  - 0xC+4*ch DATA ch, write: push wdata into FIFO ch. Reads 0. With defaults, DATA0=0x7FC.
- Addresses at or above 0xC+4*NUM_CH, or not word-aligned: sel=0, writes ignored, mem_rdata=0.
- Reset values:
  - all FIFOs empty, overflow=0
  - done=0, exit_code=0
  - drain_valid=0, drain_data=0, drain_ch=0
  - round-robin pointer=0
  - sel and mem_rdata follow inputs combinationally
- Push: a store sampled at edge E is stored in the FIFO after E. STATUS read in the following cycle shows non-empty.
- Push while full: data dropped and overflow[ch] set at E. Exception: if the same edge pops that channel into the output stage, the push is accepted.
- Overflow set and CTRL clear on the same edge: set wins.
- Output stage is a single register.
  - It loads when it is empty, or when drain_valid&drain_ready, and at least one FIFO is non-empty.
  - Loaded word is the head of the first non-empty channel searched from rr_ptr upward, wrapping at NUM_CH.
  - The granted FIFO pops on the same edge. rr_ptr becomes (grant+1) mod NUM_CH.
  - If no FIFO is non-empty on a handshake edge, drain_valid drops to 0.
- Latency: store at edge E with idle output stage gives drain_valid=1 after edge E+1. Back-to-back handshakes sustain 1 word/cycle.
- While drain_valid=1 and drain_ready=0, drain_data and drain_ch are held stable. The arbiter does not re-grant.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. Occupancy counters are log2(FIFO_DEPTH)+1 bits.
- done has no effect on FIFOs; draining continues after exit.
- Reset mid-operation: all buffered data is discarded and every output returns to its reset value.

Test Plan:
- Reset, write 0x41 to 0x7FC, drain_ready=1 -> drain_valid=1 with data 0x41, ch 0 exactly one cycle after the write edge, then drain_valid=0. STATUS=0x0000_0003.
- Hold drain_ready=0, push 9 words 1..9 to DATA0 -> FIFO full after 8 words plus 1 in the output stage, no drop. The 10th push sets STATUS bit16. CTRL write 0x1 clears it.
- Load ch0 with {A0,A1,A2} and ch1 with {B0,B1}, then raise drain_ready -> drain order A0,B0,A1,B1,A2 with matching drain_ch.
- Stall: drain_ready=0 for 5 cycles with a word pending while pushing to another channel -> drain_data and drain_ch unchanged across the stall.
- Write 0x2A then 0x7 to EXIT (0x7F8) -> done=1, exit_code=0x2A persists; STATUS bit31=1.
- Pulse rst_n low mid-stream with 3 words queued -> drain_valid=0 immediately, STATUS=0x0000_0003 after release, done=0.
